// File: rtl/gpio_link_scheduler.sv
// Round-robin scheduler for one shared 128-bit GPIO message link: grants requesters,
// sequences data_ready/done with timeout and idle gap, and captures inbound messages.
module gpio_link_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 64,
    parameter int GAP_CYCLES = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*128-1:0]   req_msg,
    output logic [NUM_REQ-1:0]       ack,
    output logic [NUM_REQ-1:0]       err,
    output logic                     busy,
    output logic                     link_data_ready,
    output logic [127:0]             link_message_out,
    input  logic                     link_done,
    input  logic                     link_received,
    input  logic [127:0]             link_message_in,
    output logic                     rx_valid,
    input  logic                     rx_ready,
    output logic [127:0]             rx_msg,
    output logic                     rx_overflow
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SEND = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_last;
    logic [IDX_W-1:0]   w_last_nxt;
    logic [IDX_W-1:0]   r_gnt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [GAP_W-1:0]   r_gap;
    logic [GAP_W-1:0]   w_gap_nxt;
    logic [NUM_REQ-1:0] r_ack;
    logic [NUM_REQ-1:0] w_ack_nxt;
    logic [NUM_REQ-1:0] r_err;
    logic [NUM_REQ-1:0] w_err_nxt;
    logic [127:0]       r_msg_out;
    logic               w_load;

    logic               w_gnt_any;
    logic [IDX_W-1:0]   w_gnt_idx;
    logic [IDX_W-1:0]   w_cand;
    logic [127:0]       w_sel_msg;

    logic               r_rcv_d;
    logic               w_rx_edge;
    logic               r_rx_valid;
    logic [127:0]       r_rx_msg;
    logic               r_rx_ovf;

    // Search starts just after the last served requester, so it becomes lowest priority.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(r_last) + k) % NUM_REQ);
            if (!w_gnt_any && req[w_cand]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    always_comb begin
        w_sel_msg = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_idx == IDX_W'(i)) begin
                w_sel_msg = req_msg[i*128 +: 128];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap;
        w_ack_nxt   = '0;
        w_err_nxt   = '0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_any) begin
                    w_load      = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                // done in the final allowed cycle still counts as delivered
                if (link_done) begin
                    w_ack_nxt   = NUM_REQ'(1) << r_gnt;
                    w_last_nxt  = r_gnt;
                    w_gap_nxt   = '0;
                    w_state_nxt = S_GAP;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_err_nxt   = NUM_REQ'(1) << r_gnt;
                    w_last_nxt  = r_gnt;
                    w_gap_nxt   = '0;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap == GAP_W'(GAP_CYCLES - 1)) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap + GAP_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_last    <= IDX_W'(NUM_REQ - 1);
            r_gnt     <= '0;
            r_cnt     <= '0;
            r_gap     <= '0;
            r_ack     <= '0;
            r_err     <= '0;
            r_msg_out <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gap   <= w_gap_nxt;
            r_ack   <= w_ack_nxt;
            r_err   <= w_err_nxt;
            if (w_load) begin
                r_gnt     <= w_gnt_idx;
                r_msg_out <= w_sel_msg;
            end
        end
    end

    // Inbound capture runs independently of the transmit sequencing.
    assign w_rx_edge = link_received & ~r_rcv_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rcv_d    <= 1'b0;
            r_rx_valid <= 1'b0;
            r_rx_msg   <= '0;
            r_rx_ovf   <= 1'b0;
        end else begin
            r_rcv_d <= link_received;
            if (w_rx_edge) begin
                if (!r_rx_valid || rx_ready) begin
                    r_rx_msg   <= link_message_in;
                    r_rx_valid <= 1'b1;
                end else begin
                    r_rx_ovf <= 1'b1;
                end
            end else if (rx_ready && r_rx_valid) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign ack              = r_ack;
    assign err              = r_err;
    assign busy             = (r_state != S_IDLE);
    assign link_data_ready  = (r_state == S_SEND);
    assign link_message_out = r_msg_out;
    assign rx_valid         = r_rx_valid;
    assign rx_msg           = r_rx_msg;
    assign rx_overflow      = r_rx_ovf;

    a_single_outcome: assert property (@(posedge clock) disable iff (reset)
        $onehot0(r_ack | r_err));
    a_outcome_in_gap: assert property (@(posedge clock) disable iff (reset)
        ((r_ack | r_err) != '0) |-> (r_state == S_GAP));

endmodule
